sensor_conditioner: RTL and testbench
=====================================

// Module: sensor_conditioner
// PURPOSE
//  Front-end stage between the board pins and the irrigation top level.
//  Synchronises and debounces the raw level sensors (H, M, L), soil/air
//  humidity and temperature sensors (Ua, Us, T) and the display-mode switch.
//  Flags physically impossible tank-level combinations.
//  Its outputs feed the irrigation, level-control and LED-matrix logic directly.
// PARAMETERS
//  DEB_CYCLES  500000  stable cycles required before an input is accepted
//                      (10 ms @ 50 MHz); legal range >= 2
//  CW          $clog2(DEB_CYCLES)  debounce counter width (derived, not overridden)
// PORTS
//  clk        in   1  system clock, all state on rising edge
//  reiniciar  in   1  asynchronous, active-high reset
//  raw_in     in   7  raw pins {switch,T,Us,Ua,L,M,H}, bit0=H ... bit6=switch
//  H, M, L    out  1  debounced level sensors
//  Ua, Us, T  out  1  debounced humidity/temperature sensors
//  switch_o   out  1  debounced display-mode switch
//  mudou      out  1  one-cycle pulse: at least one debounced output changed
//  erro_nivel out  1  debounced level combination is invalid
// BEHAVIOUR
//  Reset: all sync flops, counters and outputs clear to 0 immediately on
//   reiniciar=1, independent of clk. This includes H..switch_o, mudou and
//   erro_nivel. A reset asserted mid-debounce discards the partial count.
//  Synchroniser: 2 flops per bit (s1 <= raw_in, s2 <= s1). No other logic
//   samples raw_in.
//  Debounce, per bit, independent (cnt[CW-1:0], stable):
//   - s2 == stable: cnt <= 0.
//   - s2 != stable and cnt <  DEB_CYCLES-1: cnt <= cnt+1.
//   - s2 != stable and cnt == DEB_CYCLES-1: stable <= s2, cnt <= 0.
//   - Glitch rule: if s2 returns to stable before the terminal count, the
//     count is cleared and no output change occurs.
//  Latency: a raw change held steady from before edge 1 appears on the output
//   exactly at edge 2+DEB_CYCLES. A pulse lasting <= DEB_CYCLES-1 cycles
//   after synchronisation is never passed through.
//  Outputs are the stable registers directly, with no combinational path from raw_in.
//  mudou: registered. It goes high on the same edge that any stable bit
//   updates and stays high for exactly 1 cycle. Simultaneous updates on
//   several bits produce a single 1-cycle pulse. Back-to-back updates on
//   consecutive edges hold mudou high for both cycles.
//  erro_nivel: registered from the debounced H, M, L. It is 1 when
//   (H & ~M) | (M & ~L) | (H & ~L). It therefore lags the offending level
//   output by 1 cycle and clears 1 cycle after the combination becomes
//   legal again.
//  Legal level states: {H,M,L} = 000, 001, 011, 111.
//  The debounced level outputs are still forwarded when erro_nivel=1.
//   Downstream logic decides the reaction.
// STRUCTURE
//  Shared header (sensor_defs.vh): bit indices IDX_H..IDX_SW and the
//   default DEB_CYCLES constant. The top level uses the same indices.
//  One sub-module, debounce_bit, instantiated 7 times in a generate loop.
//   It contains the 2-flop synchroniser, the counter and the stable register,
//   with ports clk, reiniciar, din, dout, upd (1-cycle update strobe).
//  The top of this block ORs the upd strobes into mudou and contains the
//   erro_nivel check register.
// TESTING (run with DEB_CYCLES=4)
//  1. Assert reiniciar, raw_in=7'h7F -> every output is 0 during reset. After
//     release, all 7 outputs go to 1 at edge 6 and mudou=1 for that one cycle.
//  2. Set raw_in[0] (H) high for 3 cycles, then low -> H stays 0 and mudou
//     never pulses (glitch rejection).
//  3. Apply raw {H,M,L}=001, then 011, then 111, each held 10 cycles -> L, M
//     and H rise in order, each 6 edges after its raw change, and erro_nivel
//     stays 0 throughout.
//  4. From level 000, set raw H=1 only -> H=1 at edge 6, erro_nivel=1 at
//     edge 7. Then set raw M=1 and L=1 -> erro_nivel clears 1 cycle after
//     both are debounced.
//  5. Pulse reiniciar while raw_in[6]=1 and mid-count (cnt=2) -> switch_o
//     stays 0, and after release the full 6-edge latency restarts.
//  6. Change raw Ua and T on the same cycle -> both outputs update on the
//     same edge with a single 1-cycle mudou pulse.

Source files
------------

// File: rtl/sensor_conditioner_pkg.sv
// ============================================================================
// sensor_conditioner_pkg : shared sensor bit indices, defaults and level check
// Rev 1.0
// ============================================================================
`default_nettype none

package sensor_conditioner_pkg;

   localparam int IDX_H      = 0;
   localparam int IDX_M      = 1;
   localparam int IDX_L      = 2;
   localparam int IDX_UA     = 3;
   localparam int IDX_US     = 4;
   localparam int IDX_T      = 5;
   localparam int IDX_SW     = 6;
   localparam int N_SENSORS  = 7;

   // 10 ms at 50 MHz
   localparam int DEB_CYCLES_DEFAULT = 500000;

   typedef logic [N_SENSORS-1:0] sensor_vec_t;

   // A float can only be wet if every float below it is wet as well.
   function automatic logic level_invalid(input logic h, input logic m, input logic l);
      return (h & ~m) | (m & ~l) | (h & ~l);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sensor_conditioner_debounce_bit.sv
// ============================================================================
// debounce_bit : 2-flop synchroniser followed by a consecutive-sample debouncer
// Rev 1.0
// ============================================================================
`default_nettype none

module debounce_bit #(
   parameter int DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic reiniciar,
   input  logic din,
   output logic dout,
   output logic upd
);

   localparam int             CW      = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          stable_q, stable_d;

   always_comb begin
      sync1_d  = din;
      sync2_d  = sync1_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      upd      = 1'b0;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         stable_d = sync2_q;
         cnt_d    = '0;
         upd      = 1'b1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reiniciar) begin
      if (reiniciar) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   // upd marks the cycle whose closing edge loads the stable register
   assign dout = stable_q;

endmodule

`default_nettype wire

// File: rtl/sensor_conditioner.sv
// ============================================================================
// sensor_conditioner : debounced sensor front end with change pulse and
//                      tank-level plausibility flag
// Rev 1.0
// ============================================================================
`default_nettype none

module sensor_conditioner
   import sensor_conditioner_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reiniciar,
   input  logic [N_SENSORS-1:0] raw_in,
   output logic                 H,
   output logic                 M,
   output logic                 L,
   output logic                 Ua,
   output logic                 Us,
   output logic                 T,
   output logic                 switch_o,
   output logic                 mudou,
   output logic                 erro_nivel
);

   sensor_vec_t stable;
   sensor_vec_t upd_strobe;
   logic        mudou_q, mudou_d;
   logic        erro_nivel_q, erro_nivel_d;

   generate
      for (genvar i = 0; i < N_SENSORS; i++) begin : g_bit
         debounce_bit #(
            .DEB_CYCLES (DEB_CYCLES)
         ) u_deb (
            .clk       (clk),
            .reiniciar (reiniciar),
            .din       (raw_in[i]),
            .dout      (stable[i]),
            .upd       (upd_strobe[i])
         );
      end
   endgenerate

   // Strobes fire in the cycle before the load, so mudou lands on the same edge.
   always_comb begin
      mudou_d      = |upd_strobe;
      erro_nivel_d = level_invalid(stable[IDX_H], stable[IDX_M], stable[IDX_L]);
   end

   always_ff @(posedge clk or posedge reiniciar) begin
      if (reiniciar) begin
         mudou_q      <= 1'b0;
         erro_nivel_q <= 1'b0;
      end else begin
         mudou_q      <= mudou_d;
         erro_nivel_q <= erro_nivel_d;
      end
   end

   assign H          = stable[IDX_H];
   assign M          = stable[IDX_M];
   assign L          = stable[IDX_L];
   assign Ua         = stable[IDX_UA];
   assign Us         = stable[IDX_US];
   assign T          = stable[IDX_T];
   assign switch_o   = stable[IDX_SW];
   assign mudou      = mudou_q;
   assign erro_nivel = erro_nivel_q;

endmodule

`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
// ============================================================================
// tb_sensor_conditioner : scoreboard bench with a sample-window reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sensor_conditioner;

   localparam int DEB = 4;

   logic       clk = 1'b0;
   logic       reiniciar = 1'b1;
   logic [6:0] raw_in = 7'h00;
   logic       H, M, L, Ua, Us, T, switch_o, mudou, erro_nivel;

   int n_checks = 0;
   int n_pass   = 0;

   sensor_conditioner #(.DEB_CYCLES(DEB)) dut (
      .clk        (clk),
      .reiniciar  (reiniciar),
      .raw_in     (raw_in),
      .H          (H),
      .M          (M),
      .L          (L),
      .Ua         (Ua),
      .Us         (Us),
      .T          (T),
      .switch_o   (switch_o),
      .mudou      (mudou),
      .erro_nivel (erro_nivel)
   );

   always #5 clk = ~clk;

   wire [6:0] outs = {switch_o, T, Us, Ua, L, M, H};

   task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [6:0] outs;
      logic       mud;
      logic       err;
   } exp_t;

   exp_t       sb_q[$];
   logic [6:0] hist[$];   // raw samples, hist[0] = most recent edge
   logic [6:0] m_out = '0;
   logic [6:0] m_nxt;
   logic       m_err;
   logic       m_all;

   function automatic logic bad_level(input logic [6:0] o);
      return (o[0] & ~o[1]) | (o[1] & ~o[2]) | (o[0] & ~o[2]);
   endfunction

   // An output flips once DEB consecutive synchronised samples (raw taken
   // 2..DEB+1 edges ago) all disagree with it.
   always @(posedge clk or posedge reiniciar) begin
      if (reiniciar) begin
         hist.delete();
         for (int i = 0; i <= DEB; i++) hist.push_back(7'h00);
         m_out = '0;
         if (clk) sb_q.push_back('{7'h00, 1'b0, 1'b0});
      end else begin
         m_err = bad_level(m_out);
         m_nxt = m_out;
         for (int b = 0; b < 7; b++) begin
            m_all = 1'b1;
            for (int i = 1; i <= DEB; i++)
               if (hist[i][b] == m_out[b]) m_all = 1'b0;
            if (m_all) m_nxt[b] = ~m_out[b];
         end
         hist.push_front(raw_in);
         void'(hist.pop_back());
         sb_q.push_back('{m_nxt, (m_nxt != m_out), m_err});
         m_out = m_nxt;
      end
   end

   // ---------------- monitor ----------------
   exp_t e;
   always @(posedge clk) begin
      #2;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("outs",       outs,               e.outs);
         check("mudou",      {6'b0, mudou},      {6'b0, e.mud});
         check("erro_nivel", {6'b0, erro_nivel}, {6'b0, e.err});
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Edges after the current negedge until outs == target (0 if never).
   task automatic latency(input logic [6:0] target, output int lat);
      lat = 0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #3;
         if (lat == 0 && outs == target) lat = i;
      end
      @(negedge clk);
   endtask

   task automatic count_mudou(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #3;
         if (mudou) cnt++;
      end
      @(negedge clk);
   endtask

   int lat, cnt;
   int hold [7];

   initial begin
      // 1: reset with all pins high, then release
      raw_in = 7'h7F;
      cyc(3);
      reiniciar = 1'b0;
      latency(7'h7F, lat);
      check("release_latency", 7'(lat), 7'd6);
      raw_in = 7'h00;
      cyc(12);

      // 2: 3-cycle glitch on H is rejected
      raw_in = 7'h01;
      cyc(3);
      raw_in = 7'h00;
      count_mudou(12, cnt);
      check("glitch_mudou", 7'(cnt), 7'd0);

      // 3: tank fills bottom-up
      raw_in = 7'b0000100; cyc(10);
      raw_in = 7'b0000110; cyc(10);
      raw_in = 7'b0000111; cyc(10);

      // 4: H alone is implausible, then M and L make it legal
      raw_in = 7'h00; cyc(12);
      raw_in = 7'h01; cyc(10);
      check("err_h_only", {6'b0, erro_nivel}, 7'd1);
      raw_in = 7'h07; cyc(12);
      check("err_cleared", {6'b0, erro_nivel}, 7'd0);

      // 5: async reset mid-count on the switch input
      raw_in = 7'h00; cyc(12);
      raw_in = 7'h40;
      cyc(4);
      #1 reiniciar = 1'b1;
      #1 check("async_reset", {outs[5:0], mudou}, 7'h00);
      @(negedge clk);
      check("reset_switch", {6'b0, switch_o}, 7'd0);
      reiniciar = 1'b0;
      latency(7'h40, lat);
      check("restart_latency", 7'(lat), 7'd6);
      cyc(4);

      // 6: simultaneous Ua/T change gives one pulse
      raw_in = 7'h40 | 7'h08 | 7'h20;
      count_mudou(12, cnt);
      check("simul_mudou", 7'(cnt), 7'd1);

      // random phase: per-bit random hold times around the debounce window
      for (int b = 0; b < 7; b++) hold[b] = 1;
      for (int c = 0; c < 800; c++) begin
         for (int b = 0; b < 7; b++) begin
            hold[b]--;
            if (hold[b] <= 0) begin
               raw_in[b] = ~raw_in[b];
               hold[b]   = $urandom_range(1, 9);
            end
         end
         if ($urandom_range(0, 199) == 0) begin
            #1 reiniciar = 1'b1;
            @(negedge clk);
            reiniciar = 1'b0;
         end else begin
            @(negedge clk);
         end
      end

      cyc(4);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
